stick_sorter: RTL
=================

STICK_SORTER -- requirements
Module: stick_sorter

Interface
REQ-001 NUM_STICKS, 8, number of sticks held; fixed at 8 in this revision.
REQ-002 HEIGHT_W, 9, width of one stick height in pixels (max 511).
REQ-003 STEP_FRAMES, 30, frame ticks between successive compare steps; legal range 1..255.
REQ-004 pclk  input  1  pixel clock shared with vga_timing; sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 vblnk  input  1  vertical blank from vga_timing; its rising edge is the frame tick.
REQ-007 start  input  1  single-cycle request to begin sorting.
REQ-008 load_en  input  1  single-cycle write strobe for one stick height.
REQ-009 load_idx  input  3  stick index written by load_en.
REQ-010 load_height  input  HEIGHT_W  height value written by load_en.
REQ-011 heights  output  NUM_STICKS*HEIGHT_W  registered heights, stick i at bits [i*HEIGHT_W +: HEIGHT_W], feeding the stick renderer.
REQ-012 highlight_idx  output  4  left stick of the pair under comparison; 8 means none.
REQ-013 busy  output  1  high while sorting.
REQ-014 done  output  1  high from sort completion until the next accepted start or reset.
REQ-015 swap_count  output  8  swaps performed in the current or last sort; saturates at 255.

Function
REQ-016 The block SHALL implement states IDLE, SORT and DONE; busy = (state==SORT), done = (state==DONE).
REQ-017 Frame tick SHALL be vblnk high while the registered previous vblnk is low; the registered copy resets to 1 so no tick fires in the first cycle after reset.
REQ-018 load_en SHALL write load_height into stick load_idx on that edge in IDLE or DONE; in SORT it SHALL be ignored.
REQ-019 start SHALL be accepted in IDLE or DONE: next state SORT, pass=0, j=0, frame_cnt=0, pass_swapped=0, swap_count=0; start in SORT SHALL be ignored.
REQ-020 load_en and start in the same cycle SHALL both take effect; the sort uses the loaded value.
REQ-021 In SORT, frame_cnt SHALL increment on each frame tick; on a tick with frame_cnt==STEP_FRAMES-1 a step executes and frame_cnt returns to 0.
REQ-022 Step: if heights[j] > heights[j+1] (unsigned) the two SHALL swap on that edge, swap_count increments (saturating), pass_swapped sets; equal heights SHALL NOT swap.
REQ-023 Pass limit L = NUM_STICKS-1-pass; after a step with j < L-1, j increments.
REQ-024 After a step with j == L-1: if L==1 or no swap occurred in the pass (including this step), state SHALL go to DONE; otherwise pass increments, j=0, pass_swapped=0.
REQ-025 highlight_idx SHALL equal j in SORT and 8 in IDLE and DONE.
REQ-026 heights SHALL change only on load edges or step edges, always coincident with a frame tick during SORT, so no mid-frame tearing.
REQ-027 Ticks arriving in IDLE or DONE SHALL have no effect; frame_cnt holds 0 there.

Reset
REQ-028 On rst high, asynchronously: state IDLE; heights[i] = 240 - 30*i (240,210,...,30); highlight_idx 8; busy 0; done 0; swap_count 0; pass, j, frame_cnt, pass_swapped 0.
REQ-029 rst asserted mid-sort SHALL abandon the sort and restore REQ-028 values; the partial sort result is discarded.

Verification
REQ-030 Reset, no stimulus -> heights 240..30 descending, highlight_idx 8, busy 0, done 0, swap_count 0.
REQ-031 STEP_FRAMES=1, reset pattern, start, 28 vblnk pulses -> heights 30..240 ascending, swap_count 28, done high after the 28th tick, no change on further ticks.
REQ-032 STEP_FRAMES=1, load ascending 10,20,...,80, start -> 7 compares, swap_count 0, done after the 7th tick.
REQ-033 Load sticks 2 and 3 both = 100, others ascending, start -> equal pair never swaps, swap_count 0.
REQ-034 STEP_FRAMES=3, start, load_en idx 0 value 5 during SORT -> write ignored; steps occur on ticks 3, 6, 9 only; highlight_idx tracks 0,1,2.
REQ-035 rst pulse after 10 steps -> all outputs return to REQ-028 values immediately; subsequent start re-sorts from 240..30.

Source files
------------

// File: rtl/stick_sorter.sv
// Animated bubble sort of NUM_STICKS stick heights, one compare step every
// STEP_FRAMES frame ticks, so a renderer can show each compare/swap in turn.
module stick_sorter #(
    parameter int unsigned NUM_STICKS  = 8,
    parameter int unsigned HEIGHT_W    = 9,
    parameter int unsigned STEP_FRAMES = 30
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic                           vblnk,
    input  logic                           start,
    input  logic                           load_en,
    input  logic [2:0]                     load_idx,
    input  logic [HEIGHT_W-1:0]            load_height,
    output logic [NUM_STICKS*HEIGHT_W-1:0] heights,
    output logic [3:0]                     highlight_idx,
    output logic                           busy,
    output logic                           done,
    output logic [7:0]                     swap_count
);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t              state, state_next;
    logic [HEIGHT_W-1:0] h      [NUM_STICKS];
    logic [HEIGHT_W-1:0] h_next [NUM_STICKS];
    logic [2:0]          pass, pass_next;
    logic [2:0]          j, j_next;
    logic [7:0]          frame_cnt, frame_next;
    logic [7:0]          swap_next;
    logic                pass_swapped, pass_swapped_next;
    logic                vblnk_q;
    logic                tick;
    logic [3:0]          lim;
    logic                swap;
    logic                last;

    // Next-state, datapath and step logic.
    always_comb begin
        state_next        = state;
        h_next            = h;
        pass_next         = pass;
        j_next            = j;
        frame_next        = frame_cnt;
        swap_next         = swap_count;
        pass_swapped_next = pass_swapped;
        tick              = vblnk & ~vblnk_q;
        lim               = 4'(NUM_STICKS - 1) - {1'b0, pass};
        swap              = h[j] > h[j + 3'd1];
        last              = ({1'b0, j} == (lim - 4'd1));

        case (state)
            IDLE, DONE: begin
                if (load_en) begin
                    h_next[load_idx] = load_height;
                end
                if (start) begin
                    state_next        = SORT;
                    pass_next         = 3'd0;
                    j_next            = 3'd0;
                    frame_next        = 8'd0;
                    pass_swapped_next = 1'b0;
                    swap_next         = 8'd0;
                end
            end
            SORT: begin
                if (tick) begin
                    if (frame_cnt == 8'(STEP_FRAMES - 1)) begin
                        frame_next = 8'd0;
                        if (swap) begin
                            h_next[j]        = h[j + 3'd1];
                            h_next[j + 3'd1] = h[j];
                            if (swap_count != 8'hFF) begin
                                swap_next = swap_count + 8'd1;
                            end
                        end
                        if (!last) begin
                            j_next            = j + 3'd1;
                            pass_swapped_next = pass_swapped | swap;
                        end else if (lim == 4'd1 || !(pass_swapped || swap)) begin
                            state_next = DONE;
                        end else begin
                            pass_next         = pass + 3'd1;
                            j_next            = 3'd0;
                            pass_swapped_next = 1'b0;
                        end
                    end else begin
                        frame_next = frame_cnt + 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs; vblnk_q resets high to suppress a tick right after reset.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            for (int i = 0; i < NUM_STICKS; i++) begin
                h[i] <= HEIGHT_W'(240 - 30 * i);
            end
            pass          <= 3'd0;
            j             <= 3'd0;
            frame_cnt     <= 8'd0;
            swap_count    <= 8'd0;
            pass_swapped  <= 1'b0;
            vblnk_q       <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            highlight_idx <= 4'd8;
        end else begin
            state         <= state_next;
            h             <= h_next;
            pass          <= pass_next;
            j             <= j_next;
            frame_cnt     <= frame_next;
            swap_count    <= swap_next;
            pass_swapped  <= pass_swapped_next;
            vblnk_q       <= vblnk;
            busy          <= (state_next == SORT);
            done          <= (state_next == DONE);
            highlight_idx <= (state_next == SORT) ? {1'b0, j_next} : 4'd8;
        end
    end

    for (genvar i = 0; i < NUM_STICKS; i++) begin : g_flat
        assign heights[i*HEIGHT_W +: HEIGHT_W] = h[i];
    end

endmodule
